// File: rtl/memory_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM state encodings and
// common constants.
package memory_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_HOLD = 2'b10
  } mem_state_e;

  localparam logic [15:0] ZERO16 = 16'h0000;

endpackage

// File: rtl/memory_stage_ctrl_if.sv
// Data-memory request/response bus between the memory-stage controller
// (master) and the cache-backed data memory (slave).
interface memory_stage_ctrl_if;

  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_done;
  logic        mem_stall;
  logic [15:0] mem_data_out;

  modport master (
    output mem_addr, mem_data_in, mem_rd, mem_wr,
    input  mem_done, mem_stall, mem_data_out
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_rd, mem_wr,
    output mem_done, mem_stall, mem_data_out
  );

endinterface

// File: rtl/memory_stage_ctrl_mem_wait_counter.sv
// Cycle counter with synchronous clear and enable, flagging when it reaches
// LIMIT. Shared with the fetch-side controller.
module mem_wait_counter #(
  parameter int CNT_W = 7,
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/memory_stage_ctrl.sv
// Memory-stage controller: issues loads/stores to a multi-cycle data memory,
// freezes the pipeline while a miss is outstanding, and flags errors.
module memory_stage_ctrl
  import memory_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                       clk,
  input  logic                       global_rst,
  input  logic                       valid_EM,
  input  logic                       mem_read_en_EM,
  input  logic                       mem_write_en_EM,
  input  logic [15:0]                ALU_result_EM,
  input  logic [15:0]                write_data_EM,
  memory_stage_ctrl_if.master        mem,
  output logic [15:0]                read_data_MWB_in,
  output logic                       freeze_pipe,
  output logic                       align_err,
  output logic                       timeout_err
);

  mem_state_e  state;
  logic [15:0] hold_q;
  logic        req, misaligned, aligned_req, issue, hit, miss_issue;
  logic        cnt_en, cnt_tc;

  assign req         = valid_EM & (mem_read_en_EM | mem_write_en_EM);
  assign misaligned  = req & ALU_result_EM[0];
  assign aligned_req = req & ~ALU_result_EM[0];
  assign issue       = (state == MEM_IDLE) & aligned_req & ~mem.mem_stall;
  assign hit         = issue & mem.mem_done;
  assign miss_issue  = issue & ~mem.mem_done;

  assign mem.mem_addr    = ALU_result_EM;
  assign mem.mem_data_in = write_data_EM;

  // Counter holds the WAIT-cycle index: it steps to 1 on the issuing cycle.
  assign cnt_en = miss_issue | (state == MEM_WAIT);

  mem_wait_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (global_rst),
    .clr (~cnt_en),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    mem.mem_rd       = 1'b0;
    mem.mem_wr       = 1'b0;
    freeze_pipe      = 1'b0;
    read_data_MWB_in = ZERO16;
    case (state)
      MEM_IDLE: begin
        if (issue) begin
          mem.mem_rd = mem_read_en_EM;
          mem.mem_wr = mem_write_en_EM & ~mem_read_en_EM;
        end
        freeze_pipe      = aligned_req & ~hit;
        read_data_MWB_in = hit ? mem.mem_data_out : ZERO16;
      end
      MEM_WAIT: freeze_pipe = 1'b1;
      MEM_HOLD: read_data_MWB_in = hold_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      state       <= MEM_IDLE;
      hold_q      <= ZERO16;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (misaligned) align_err <= 1'b1;
          if (miss_issue) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem.mem_done) begin
            hold_q <= mem.mem_data_out;
            state  <= MEM_HOLD;
          end else if (cnt_tc) begin
            timeout_err <= 1'b1;
            hold_q      <= ZERO16;
            state       <= MEM_HOLD;
          end
        end
        // The completed instruction is still in EX/MEM here; never re-issue.
        MEM_HOLD: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Self-checking bench: directed and random accesses checked cycle by cycle
// against a transaction-level model built from the latency rules.
module tb_memory_stage_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        global_rst;
  logic        valid_EM, mem_read_en_EM, mem_write_en_EM;
  logic [15:0] ALU_result_EM, write_data_EM;
  logic [15:0] read_data_MWB_in;
  logic        freeze_pipe, align_err, timeout_err;

  int n_vec = 0;
  int n_bad = 0;
  logic exp_align   = 1'b0;
  logic exp_timeout = 1'b0;

  memory_stage_ctrl_if bus ();

  memory_stage_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
    .clk              (clk),
    .global_rst       (global_rst),
    .valid_EM         (valid_EM),
    .mem_read_en_EM   (mem_read_en_EM),
    .mem_write_en_EM  (mem_write_en_EM),
    .ALU_result_EM    (ALU_result_EM),
    .write_data_EM    (write_data_EM),
    .mem              (bus.master),
    .read_data_MWB_in (read_data_MWB_in),
    .freeze_pipe      (freeze_pipe),
    .align_err        (align_err),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are already set at the negedge; sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic e_rd, input logic e_wr,
                     input logic e_frz, input logic [15:0] e_rdata);
    #1;
    check($sformatf("%s.rd", tag),      {15'b0, bus.mem_rd},      {15'b0, e_rd});
    check($sformatf("%s.wr", tag),      {15'b0, bus.mem_wr},      {15'b0, e_wr});
    check($sformatf("%s.freeze", tag),  {15'b0, freeze_pipe},     {15'b0, e_frz});
    check($sformatf("%s.rdata", tag),   read_data_MWB_in,         e_rdata);
    check($sformatf("%s.addr", tag),    bus.mem_addr,             ALU_result_EM);
    check($sformatf("%s.wdata", tag),   bus.mem_data_in,          write_data_EM);
    check($sformatf("%s.align", tag),   {15'b0, align_err},       {15'b0, exp_align});
    check($sformatf("%s.timeout", tag), {15'b0, timeout_err},     {15'b0, exp_timeout});
    @(negedge clk);
  endtask

  task automatic idle_cycle(input string tag);
    valid_EM        = 1'($urandom_range(0, 1));
    mem_read_en_EM  = 1'b0;
    mem_write_en_EM = 1'b0;
    ALU_result_EM   = 16'($urandom);
    write_data_EM   = 16'($urandom);
    bus.mem_done    = 1'b0;
    bus.mem_stall   = 1'($urandom_range(0, 1));
    bus.mem_data_out = 16'($urandom);
    cyc(tag, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic misaligned(input string tag, input logic [15:0] addr, input logic rd, input logic wr);
    valid_EM = 1'b1; mem_read_en_EM = rd; mem_write_en_EM = wr;
    ALU_result_EM = addr; write_data_EM = 16'($urandom);
    bus.mem_done = 1'($urandom_range(0, 1)); bus.mem_stall = 1'($urandom_range(0, 1));
    bus.mem_data_out = 16'($urandom);
    cyc(tag, 1'b0, 1'b0, 1'b0, 16'h0000);
    exp_align = 1'b1;
  endtask

  // lat = 0: hit; lat > 0: mem_done lat cycles after the strobe; lat < 0: never.
  task automatic access(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic rd, input logic wr, input int stalls, input int lat,
                        input logic [15:0] rdata);
    int n_wait;
    logic [15:0] held;
    valid_EM = 1'b1; mem_read_en_EM = rd; mem_write_en_EM = wr;
    ALU_result_EM = addr; write_data_EM = wdata;
    for (int s = 0; s < stalls; s++) begin
      bus.mem_stall = 1'b1; bus.mem_done = 1'b0; bus.mem_data_out = 16'($urandom);
      cyc($sformatf("%s.stall%0d", tag, s), 1'b0, 1'b0, 1'b1, 16'h0000);
    end
    bus.mem_stall = 1'b0;
    bus.mem_done  = (lat == 0);
    bus.mem_data_out = (lat == 0) ? rdata : 16'($urandom);
    cyc($sformatf("%s.strobe", tag), rd, wr & ~rd, lat != 0, (lat == 0) ? rdata : 16'h0000);
    if (lat == 0) return;
    n_wait = (lat > 0) ? lat : TIMEOUT;
    for (int k = 1; k <= n_wait; k++) begin
      bus.mem_stall = 1'($urandom_range(0, 1));
      bus.mem_done  = (k == lat);
      bus.mem_data_out = (k == lat) ? rdata : 16'($urandom);
      cyc($sformatf("%s.wait%0d", tag, k), 1'b0, 1'b0, 1'b1, 16'h0000);
    end
    if (lat < 0) exp_timeout = 1'b1;
    held = (lat > 0) ? rdata : 16'h0000;
    bus.mem_done = 1'b0; bus.mem_stall = 1'($urandom_range(0, 1));
    bus.mem_data_out = 16'($urandom);
    cyc($sformatf("%s.hold", tag), 1'b0, 1'b0, 1'b0, held);
  endtask

  task automatic random_phase(input string tag, input int n);
    int kind;
    logic [1:0] rw;
    for (int t = 0; t < n; t++) begin
      kind = $urandom_range(0, 9);
      rw   = 2'($urandom_range(1, 3));
      if (kind == 0)
        misaligned($sformatf("%s%0d.mis", tag, t), 16'($urandom) | 16'h0001, rw[0], rw[1]);
      else if (kind == 1)
        idle_cycle($sformatf("%s%0d.idle", tag, t));
      else
        access($sformatf("%s%0d", tag, t), 16'($urandom) & 16'hFFFE, 16'($urandom),
               rw[0], rw[1], $urandom_range(0, 2), $urandom_range(0, 5), 16'($urandom));
    end
  endtask

  initial begin
    global_rst = 1'b1;
    valid_EM = 1'b0; mem_read_en_EM = 1'b0; mem_write_en_EM = 1'b0;
    ALU_result_EM = 16'h0000; write_data_EM = 16'h0000;
    bus.mem_done = 1'b0; bus.mem_stall = 1'b0; bus.mem_data_out = 16'h0000;
    @(negedge clk); @(negedge clk);
    global_rst = 1'b0;
    idle_cycle("reset");

    access("hit_ld",   16'h0010, 16'h0000, 1'b1, 1'b0, 0, 0, 16'hBEEF);
    access("miss_st",  16'h0020, 16'h1234, 1'b0, 1'b1, 0, 3, 16'h5A5A);
    access("miss_ld",  16'h0040, 16'h0000, 1'b1, 1'b0, 0, 2, 16'hA5A5);
    access("both_en",  16'h0042, 16'h7777, 1'b1, 1'b1, 0, 1, 16'h0F0F);

    misaligned("odd_ld", 16'h0031, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle_cycle($sformatf("sticky%0d", i));

    access("timeout", 16'h0050, 16'h0000, 1'b1, 1'b0, 0, -1, 16'h0000);
    idle_cycle("post_to");
    access("after_to", 16'h0052, 16'h0000, 1'b1, 1'b0, 1, 0, 16'hC0DE);

    random_phase("rnd_a", 25);

    valid_EM = 1'b1; mem_read_en_EM = 1'b1; mem_write_en_EM = 1'b0;
    ALU_result_EM = 16'h0100; write_data_EM = 16'h0000;
    bus.mem_stall = 1'b0; bus.mem_done = 1'b0; bus.mem_data_out = 16'h1111;
    cyc("rst_strobe", 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int i = 1; i <= 3; i++) cyc($sformatf("rst_wait%0d", i), 1'b0, 1'b0, 1'b1, 16'h0000);
    global_rst = 1'b1; valid_EM = 1'b0;
    @(negedge clk);
    global_rst = 1'b0;
    exp_align = 1'b0; exp_timeout = 1'b0;
    cyc("rst_after", 1'b0, 1'b0, 1'b0, 16'h0000);
    access("rst_hit", 16'h0102, 16'h0000, 1'b1, 1'b0, 0, 0, 16'h2468);

    access("stall2", 16'h0200, 16'h0000, 1'b1, 1'b0, 2, 2, 16'h3C3C);
    access("stall_st", 16'h0204, 16'hABCD, 1'b0, 1'b1, 2, 0, 16'h9999);

    random_phase("rnd_b", 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage_ctrl.md
Name: memory_stage_ctrl

Overview:
- Memory-stage controller sitting between the EX/MEM pipeline register and memory_WriteBack_FF.
- Issues load/store requests to a multi-cycle data memory (cache-backed, done/stall handshake).
- Freezes the pipeline while a request is outstanding.
- Presents load data, via a holding register, to the MEM/WB flops.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before a timeout error is flagged.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- global_rst  in  1  synchronous active-high reset
- valid_EM  in  1  EX/MEM slot holds a real instruction
- mem_read_en_EM  in  1  load request
- mem_write_en_EM  in  1  store request
- ALU_result_EM  in  16  effective address
- write_data_EM  in  16  store data
- mem_done  in  1  memory completed the accepted request; data valid this cycle
- mem_stall  in  1  memory busy, cannot accept a new request
- mem_data_out  in  16  read data from memory
- mem_addr  out  16  address to memory
- mem_data_in  out  16  write data to memory
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- read_data_MWB_in  out  16  load data to memory_WriteBack_FF
- freeze_pipe  out  1  freeze for all upstream FFs and memory_WriteBack_FF
- align_err  out  1  sticky misaligned-access flag
- timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset is synchronous on global_rst. Reset values:
  - state = IDLE
  - wait counter = 0
  - read-data hold register = 0x0000
  - align_err = 0, timeout_err = 0
- Reset mid-request abandons the request; memory-side cleanup is the memory's responsibility.
- req = valid_EM & (mem_read_en_EM | mem_write_en_EM). If both enables are set, the access is treated as a read; no write occurs.
- Misaligned: req with ALU_result_EM[0] = 1.
  - No strobe is issued and no freeze occurs.
  - align_err is set next cycle and stays set until reset.
  - read_data_MWB_in = 0x0000 for that instruction.
- mem_addr = ALU_result_EM and mem_data_in = write_data_EM, combinationally, at all times.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - Aligned req with mem_stall = 0: assert mem_rd/mem_wr for exactly this cycle.
    - mem_done in the same cycle (hit): read_data_MWB_in = mem_data_out, freeze_pipe = 0, stay in IDLE.
    - Otherwise: freeze_pipe = 1, go to WAIT, counter := 1.
  - Aligned req with mem_stall = 1: no strobe, freeze_pipe = 1, stay in IDLE and retry the next cycle.
  - No req: freeze_pipe = 0, strobes = 0.
- WAIT:
  - Strobes = 0 and freeze_pipe = 1; the counter increments each cycle.
  - mem_done: capture mem_data_out into the hold register, go to HOLD. freeze_pipe stays 1 in this cycle.
  - Counter reaches TIMEOUT_CYCLES without mem_done: set timeout_err (sticky), force the hold register to 0x0000, go to HOLD.
- HOLD:
  - freeze_pipe = 0 for exactly one cycle; read_data_MWB_in = hold register; strobes = 0; next state IDLE.
  - The instruction still present in EX/MEM is the one just completed. HOLD must not re-issue it.
  - The following IDLE cycle sees the new EX/MEM contents.
- read_data_MWB_in:
  - In IDLE, mem_data_out when a hit occurs.
  - In HOLD, the hold register.
  - 0x0000 otherwise.
- Store data is never written back; the reg_src mux downstream ignores read data for stores.
- Latency:
  - Hit: 0 extra cycles.
  - Miss completing N cycles after the strobe: N+1 frozen cycles (N cycles in WAIT), then one HOLD cycle.

Decomposition:
- Shared package: state encodings MEM_IDLE = 2'b00, MEM_WAIT = 2'b01, MEM_HOLD = 2'b10, and the constant ZERO16.
- One sub-module, mem_wait_counter: a CNT_W-bit counter with sync clear and enable that exposes a terminal-count flag. It is reused for the fetch-side controller.

Test Plan:
- Aligned load to 0x0010 with mem_done in the same cycle, mem_data_out = 0xBEEF -> one mem_rd pulse; freeze_pipe stays 0; read_data_MWB_in = 0xBEEF in that cycle.
- Aligned store to 0x0020 (data 0x1234) with mem_done 3 cycles after the strobe -> one mem_wr pulse; mem_data_in = 0x1234; freeze_pipe = 1 for 4 cycles, then 0 for the HOLD cycle; no second strobe.
- Load from 0x0040 with mem_done after 2 WAIT cycles and data 0xA5A5 -> freeze_pipe high for 3 cycles; read_data_MWB_in = 0xA5A5 in the HOLD cycle; state returns to IDLE.
- Load to 0x0031 (odd address) -> no strobe; freeze_pipe = 0; align_err = 1 next cycle and still 1 after 10 further cycles.
- Load issued but mem_done never asserted (TIMEOUT_CYCLES = 64) -> timeout_err rises after 64 WAIT cycles; read_data_MWB_in = 0x0000 in HOLD; freeze_pipe released.
- global_rst asserted during WAIT, and separately mem_stall held 2 cycles before acceptance:
  - Reset: next cycle state IDLE, freeze_pipe = 0, both error flags 0.
  - Stall: no strobe while stalled; exactly one strobe in the first cycle mem_stall = 0.
